eight_bit_divider_module: RTL and testbench

Sequential restoring divider that inverts `eight_bit_multipiler_module`. It divides a 16-bit dividend (product width) by an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. It resolves one quotient bit per clock over a start/ready/done handshake, so any product can be checked by round-trip: (a*b)/a returns quotient b and remainder 0.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_restoring_step.sv | 27 ++
 rtl/eight_bit_divider_module.sv | 109 ++++++++++
 tb/tb_eight_bit_divider_module.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned STEPS = WIDTH;
   localparam logic [WIDTH-1:0] Q_SAT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit into Q.
module div_restoring_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_r,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_r,
   output logic [WIDTH-1:0] o_q
);
   import div_pkg::*;

   logic [WIDTH:0] w_t;

   always_comb begin
      w_t = {i_r, i_q[WIDTH-1]};
      o_r = w_t[WIDTH-1:0];
      o_q = {i_q[WIDTH-2:0], 1'b0};
      // i_r < i_divisor on entry, so the difference always fits back in WIDTH bits
      if (w_t >= {1'b0, i_divisor}) begin
         o_r = WIDTH'(w_t - {1'b0, i_divisor});
         o_q = {i_q[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/eight_bit_divider_module.sv
// Sequential 2W/W restoring divider with start/ready/done handshake; saturates the
// quotient and flags the result when the divisor is zero or the quotient overflows.
module eight_bit_divider_module #(
   parameter int unsigned WIDTH = div_pkg::WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 ready,
   output logic                 done,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero,
   output logic                 overflow
);
   import div_pkg::*;

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_div;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   w_step_r;
   logic [WIDTH-1:0]   w_step_q;
   logic               w_zero;
   logic               w_ovf;

   assign w_zero = (divisor == '0);
   assign w_ovf  = (dividend[2*WIDTH-1:WIDTH] >= divisor);

   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .i_r       (r_rem),
      .i_q       (r_q),
      .i_divisor (r_div),
      .o_r       (w_step_r),
      .o_q       (w_step_q)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      ready        = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) w_next_state = (w_zero || w_ovf) ? DONE : RUN;
         end
         RUN:  if (r_count == LAST_STEP) w_next_state = DONE;
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_count     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               if (w_zero || w_ovf) begin
                  div_by_zero <= w_zero;
                  overflow    <= !w_zero;
                  quotient    <= '1;
                  remainder   <= dividend[WIDTH-1:0];
               end else begin
                  r_rem       <= dividend[2*WIDTH-1:WIDTH];
                  r_q         <= dividend[WIDTH-1:0];
                  r_div       <= divisor;
                  r_count     <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            RUN: begin
               r_rem   <= w_step_r;
               r_q     <= w_step_q;
               r_count <= r_count + 1'b1;
               if (r_count == LAST_STEP) begin
                  quotient  <= w_step_q;
                  remainder <= w_step_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eight_bit_divider_module.sv
// Scoreboard bench: the driver queues arithmetic-model results on acceptance and a
// monitor pops and compares them, including latency, whenever done is seen.
module tb_eight_bit_divider_module;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      logic       ovf;
      int         acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        ready, done, div_by_zero, overflow;
   logic [7:0]  quotient, remainder;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   eight_bit_divider_module #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] n, input logic [7:0] d, input int acc);
      exp_t        e;
      int unsigned quo;
      e.acc = acc;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (d == 8'd0) begin
         e.dbz = 1'b1;
         e.q   = 8'hFF;
         e.r   = n[7:0];
      end else begin
         quo = int'(n) / int'(d);
         if (quo > 255) begin
            e.ovf = 1'b1;
            e.q   = 8'hFF;
            e.r   = n[7:0];
         end else begin
            e.q = quo[7:0];
            e.r = 8'(int'(n) % int'(d));
         end
      end
      return e;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", div_by_zero, e.dbz);
               chk("overflow", overflow, e.ovf);
               chk("done_latency", cyc - e.acc, (e.dbz || e.ovf) ? 0 : 8);
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   // Waits (bounded) for ready, then presents the operands for one accepting edge.
   task automatic issue(input logic [15:0] n, input logic [7:0] d, input bit keep,
                        output int acc);
      int w = 0;
      @(negedge clk);
      dividend = n;
      divisor  = d;
      start    = 1'b1;
      while (ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (ready !== 1'b1) begin
         chk("ready_wait", 0, 1);
         start = 1'b0;
         acc   = -1;
         return;
      end
      acc = cyc + 1;
      sb.push_back(model(n, d, acc));
      @(posedge clk);
      if (!keep) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      @(negedge clk);
      while (ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (ready !== 1'b1) chk("idle_wait", 0, 1);
   endtask

   initial begin
      int acc, acc2, lows;
      logic [15:0] n;
      logic [7:0]  d, a, b;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_ovf", overflow, 0);

      issue(16'h042E, 8'h05, 0, acc);
      wait_idle();

      // Count negedges with ready low; the next acceptable edge follows one later.
      issue(16'h1BB8, 8'hAD, 0, acc);
      lows = 1;
      while (ready !== 1'b1 && lows < 40) begin
         @(negedge clk);
         if (ready !== 1'b1) lows++;
      end
      chk("accept_to_ready_edges", lows + 1, 10);

      issue(16'h1234, 8'h00, 0, acc);
      wait_idle();
      issue(16'h0500, 8'h05, 0, acc);
      wait_idle();
      issue(16'h04FF, 8'h05, 0, acc);
      wait_idle();

      // New start at step 4 must be ignored.
      issue(16'h3A7C, 8'h61, 0, acc);
      repeat (3) @(negedge clk);
      dividend = 16'h0010;
      divisor  = 8'h03;
      start    = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Start held high across two operations: second accepted as soon as ready returns.
      issue(16'h00FF, 8'h10, 1, acc);
      issue(16'h2001, 8'h21, 0, acc2);
      chk("back_to_back_interval", acc2 - acc, 10);
      wait_idle();

      // Reset at step 5 abandons the operation.
      issue(16'h7F00, 8'h80, 0, acc);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      chk("midrun_rst_ready", ready, 1);
      chk("midrun_rst_done", done, 0);
      chk("midrun_rst_quotient", quotient, 0);
      chk("midrun_rst_remainder", remainder, 0);
      chk("midrun_rst_dbz", div_by_zero, 0);
      chk("midrun_rst_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      issue(16'h7F00, 8'h80, 0, acc);
      wait_idle();

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 7))
            0: begin
               d = 8'h00;
               n = 16'($urandom);
            end
            1, 2: begin
               a = 8'($urandom_range(1, 255));
               b = 8'($urandom);
               n = 16'(a) * 16'(b);
               d = a;
            end
            3: begin
               d = 8'($urandom_range(1, 255));
               n = {8'($urandom_range(int'(d), 255)), 8'($urandom)};
            end
            default: begin
               d = 8'($urandom_range(1, 255));
               n = {8'($urandom_range(0, int'(d) - 1)), 8'($urandom)};
            end
         endcase
         issue(n, d, 0, acc);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
